// File: rtl/sm_regport_pkg.sv
// Shared types and constants for the CPU debug register-port arbiter.
package sm_regport_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Converts a one-hot grant vector (bit 0 = A, bit 1 = B) into a requester id.
  function automatic req_id_e grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/sm_rr_arbiter2.sv
// Two-way combinational arbiter: round-robin by default, fixed A-priority
// when SM_REGPORT_PRIO_EN is defined. The last_grant flop lives in the parent.
module sm_rr_arbiter2
  import sm_regport_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

`ifdef SM_REGPORT_PRIO_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Pick one requester; on a tie the one not served last goes first.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef SM_REGPORT_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/sm_regport_arbiter.sv
// Shares the CPU debug register read port between two requesters.
// Optional fixed-priority arbitration via SM_REGPORT_PRIO_EN.
module sm_regport_arbiter
  import sm_regport_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_M1_C = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1'b1);

  state_e            state_r;
  req_id_e           owner_r;
  req_id_e           last_grant_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        grant_s;
  logic              arb_en_s;
  req_id_e           winner_s;
  logic [ADDR_W-1:0] winner_addr_s;

  assign arb_en_s = (state_r == ST_IDLE);

  sm_rr_arbiter2 u_arb (
    .req        ({b_req, a_req}),
    .last_grant (last_grant_r),
    .enable     (arb_en_s),
    .grant      (grant_s)
  );

  // Route the granted requester's id and address toward the port.
  always_comb begin
    winner_s      = grant_to_id(grant_s);
    winner_addr_s = a_addr;
    if (grant_s[1]) begin
      winner_addr_s = b_addr;
    end else begin
      winner_addr_s = a_addr;
    end
  end

  // Transaction FSM: latch address, wait out the settle window, capture and ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= REQ_A;
      last_grant_r <= REQ_B;
      cnt_r        <= '0;
      regAddr      <= '0;
      a_data       <= '0;
      b_data       <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            regAddr      <= winner_addr_s;
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
            cnt_r        <= SETTLE_M1_C;
            busy         <= 1'b1;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_ONE_C;
          end else begin
            // Only the owner's data register is touched.
            if (owner_r == REQ_B) begin
              b_data <= regData;
              b_ack  <= 1'b1;
            end else begin
              a_data <= regData;
              a_ack  <= 1'b1;
            end
            state_r <= ST_ACK;
          end
        end
        ST_ACK: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
